// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/acknowledge bus between the fetch
//                stage (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 16
);
   logic [PC_W-1:0]    memAddr;
   logic               memReq;
   logic               memAck;
   logic [INSTR_W-1:0] memData;

   modport master (
      output memAddr,
      output memReq,
      input  memAck,
      input  memData
   );

   modport slave (
      input  memAddr,
      input  memReq,
      output memAck,
      output memData
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, requests one 16-bit word
//                at a time from instruction memory, issues it to the decoder
//                for one cycle (held while stalled) and selects the next PC
//                from the decoder's jump/branch controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int              PC_W     = 10,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   fetch_unit_if.master       mem,
   output logic [INSTR_W-1:0] instr,
   output logic               instrValid,
   output logic [PC_W-1:0]    pc,
   input  logic               stall,
   input  logic               jmpEnable,
   input  logic [PC_W-1:0]    jmpDir,
   input  logic               branchEnable,
   input  logic [5:0]         branchDir
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t             state_q;
   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    pc_d;
   logic [INSTR_W-1:0] instr_q;
   logic [PC_W-1:0]    w_branch_off;
   logic [PC_W-1:0]    w_one;

   // Branch offset is relative to the branching instruction's own address.
   assign w_branch_off = {{(PC_W-6){branchDir[5]}}, branchDir};
   assign w_one        = {{(PC_W-1){1'b0}}, 1'b1};

   // Next-PC selection: jump beats branch beats sequential; wraps mod 2^PC_W.
   always_comb begin
      pc_d = pc_q + w_one;
      if (jmpEnable) begin
         pc_d = jmpDir;
      end else if (branchEnable) begin
         pc_d = pc_q + w_branch_off;
      end
   end

   // Fetch FSM: request, capture on ack, issue until not stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
            end
            S_REQ: begin
               if (mem.memAck) begin
                  instr_q <= mem.memData;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!stall) begin
                  pc_q    <= pc_d;
                  state_q <= S_REQ;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs come only from registers or the state decode.
   assign mem.memAddr = pc_q;
   assign mem.memReq  = (state_q == S_REQ);
   assign instrValid  = (state_q == S_ISSUE);
   assign instr       = instr_q;
   assign pc          = pc_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the program counter and requests 16-bit instruction words from instruction memory.
- Presents each captured word to the decoder's instruction input for one issue cycle.
- Consumes the decoder's jump/branch enables and addresses to select the next PC.

Parameters:
- PC_W, 10, program-counter and memory-address width; matches the decoder's 10-bit jump/memory address fields.
- INSTR_W, 16, instruction width; opcode is [15:10].
- RESET_PC, 0, first fetch address after reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
memAddr  out  PC_W  instruction memory address
memReq  out  1  fetch request; held high until memAck
memAck  in  1  memory has valid memData this cycle
memData  in  INSTR_W  instruction word from memory
instr  out  INSTR_W  instruction register, feeds the decoder's instruction input
instrValid  out  1  instr is being issued this cycle
pc  out  PC_W  address of the word held in instr
stall  in  1  downstream hold request; freezes the issue cycle
jmpEnable  in  1  from decoder: take an absolute jump
jmpDir  in  PC_W  from decoder: absolute jump target
branchEnable  in  1  from decoder: take the branch; condition already resolved
branchDir  in  6  from decoder: signed two's-complement branch offset

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, pc=RESET_PC, instr=0, instrValid=0, memReq=0, memAddr=RESET_PC.
  - Asserting reset mid-request drops memReq immediately. The outstanding request is abandoned, and a late memAck is ignored.
- FSM states: IDLE, REQ, ISSUE.
- IDLE:
  - Lasts one cycle after reset is released.
  - Then goes to REQ.
- REQ:
  - memReq=1, memAddr=pc; both are stable until memAck.
  - On a clk edge with memAck=1: instr<=memData, go to ISSUE.
  - memAck in the first REQ cycle is legal (zero wait states).
  - memAck outside REQ is ignored.
- ISSUE:
  - instrValid=1, memReq=0.
  - The decoder is combinational, so jmpEnable, branchEnable, jmpDir and branchDir are sampled in this cycle.
  - If stall=1: remain in ISSUE. pc and instr are held, instrValid stays 1, and the enables are re-evaluated every cycle.
  - If stall=0, at the clk edge pc is updated by priority:
    1. jmpEnable=1: pc <= jmpDir (jump wins if both enables are high).
    2. branchEnable=1: pc <= pc + sign_extend(branchDir), range -32..+31, relative to the branch's own address.
    3. Otherwise: pc <= pc + 1.
  - After the update, go to REQ.
- Arithmetic: all PC arithmetic is modulo 2^PC_W (0x3FF+1 = 0x000; 0x000-1 = 0x3FF).
- Branch offset 0 re-fetches the same instruction (legal self-loop).
- Throughput: 1 instruction per (1 + memory wait) + 1 cycles. With zero-wait memory that is 2 cycles per instruction. There is no prefetch and nothing to flush.
- instr is only ever written in REQ on memAck. Outside ISSUE it holds the last word, but it is not valid.
- All outputs are registered or decoded purely from state; there are no combinational paths from inputs to outputs.

Test Plan:
- Release reset, memAck tied high → memAddr sequence 0x000, 0x001, 0x002; instrValid pulses every 2nd cycle; pc matches each issued word.
- memAck delayed 3 cycles at pc=0x004 → memReq/memAddr=0x004 held for 4 cycles; instr captures memData=0xA5C3 only on the ack edge; exactly one instrValid pulse.
- In ISSUE at pc=0x010, jmpEnable=1, jmpDir=0x3F0, branchEnable=1 → next memAddr=0x3F0 (jump priority).
- At pc=0x005, branchEnable=1, branchDir=6'b111110 → next memAddr=0x003. At pc=0x3FE, branchDir=+3 → next memAddr=0x001 (wrap).
- stall=1 for 5 cycles in ISSUE at pc=0x020 → instrValid stays 1, pc and instr are constant, memReq=0; the cycle after stall drops, memAddr=0x021.
- reset driven low mid-REQ with memAck arriving in the same cycle → memReq=0 and instrValid=0 immediately, instr=0; after release, the first fetch address is RESET_PC.
